// File: rtl/lstm_seq_ctrl_if.sv
// Signal bundle between the LSTM sequencer, the feature stream, the LSTM cell
// and the final-hidden-state consumer. The sequencer takes the slave side.
interface lstm_seq_ctrl_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;
    logic       cell_en;
    logic [7:0] cell_in;
    logic [7:0] cell_prevh;
    logic [7:0] cell_ci;
    logic       cell_cip;
    logic [7:0] cell_hout;
    logic [7:0] cell_cout;
    logic       cell_of;
    logic       h_valid;
    logic [7:0] h_data;
    logic       h_of;
    logic       h_ready;
    logic       busy;

    modport slave (
        input  s_valid, s_data, s_last, cell_hout, cell_cout, cell_of, h_ready,
        output s_ready, cell_en, cell_in, cell_prevh, cell_ci, cell_cip,
               h_valid, h_data, h_of, busy
    );

    modport master (
        output s_valid, s_data, s_last, cell_hout, cell_cout, cell_of, h_ready,
        input  s_ready, cell_en, cell_in, cell_prevh, cell_ci, cell_cip,
               h_valid, h_data, h_of, busy
    );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Sequencer for the 8-bit LSTM cell: buffers feature samples, issues one per
// timestep, recirculates Hout/Cout and presents the final hidden state.
//
// state   | meaning
// IDLE    | nothing to issue, waiting for a buffered sample
// ISSUE   | pop head, strobe the cell with sample and recurrent state
// WAIT    | let the cell pipeline settle for LAT cycles
// CAPTURE | latch Hout/Cout/Of, pick next step, end or starve
// DONE    | present final hidden state until the consumer accepts it
module lstm_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    lstm_seq_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [8:0]    head;

    logic [2:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [7:0]    h_reg, c_reg;
    logic          of_sticky, first_flag, last_reg;
    logic          in_issue, in_done;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = bus.s_valid & ~full;
    assign pop   = in_issue & ~empty;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.s_last, bus.s_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            h_reg      <= '0;
            c_reg      <= '0;
            of_sticky  <= 1'b0;
            first_flag <= 1'b1;
            last_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) state <= ISSUE;
                ISSUE: begin
                    last_reg <= head[8];
                    wait_cnt <= CW'(LAT);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == CW'(1)) state <= CAPTURE;
                end
                CAPTURE: begin
                    h_reg      <= bus.cell_hout;
                    c_reg      <= bus.cell_cout;
                    of_sticky  <= of_sticky | bus.cell_of;
                    first_flag <= 1'b0;
                    // without last and nothing queued, idle but keep the recurrent state
                    if (last_reg)    state <= DONE;
                    else if (!empty) state <= ISSUE;
                    else             state <= IDLE;
                end
                DONE: if (bus.h_ready) begin
                    h_reg      <= '0;
                    c_reg      <= '0;
                    of_sticky  <= 1'b0;
                    first_flag <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_issue = (state == ISSUE);
    assign in_done  = (state == DONE);

    assign bus.s_ready    = ~full;
    assign bus.cell_en    = in_issue;
    assign bus.cell_in    = in_issue ? head[7:0] : 8'd0;
    assign bus.cell_prevh = in_issue ? h_reg : 8'd0;
    assign bus.cell_ci    = in_issue ? c_reg : 8'd0;
    assign bus.cell_cip   = in_issue & first_flag;
    assign bus.h_valid    = in_done;
    assign bus.h_data     = in_done ? h_reg : 8'd0;
    assign bus.h_of       = in_done & of_sticky;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl with a 2-cycle behavioural LSTM cell model
// (Hout = In+PrevH, Cout = Ci+1, Of = carry).
module tb_lstm_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    lstm_seq_ctrl_if bus ();

    lstm_seq_ctrl #(.DEPTH(16), .LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [7:0] p_h = '0, p_c = '0;
    logic       p_of = 1'b0;
    always @(posedge clk) begin
        if (bus.cell_en) begin
            {p_of, p_h} <= {1'b0, bus.cell_in} + {1'b0, bus.cell_prevh};
            p_c         <= bus.cell_ci + 8'd1;
        end
        bus.cell_hout <= p_h;
        bus.cell_cout <= p_c;
        bus.cell_of   <= p_of;
    end

    typedef struct {
        int         cyc;
        logic [7:0] din;
        logic [7:0] prevh;
        logic [7:0] ci;
        logic       cip;
    } en_t;
    typedef struct {
        logic [7:0] d;
        logic       o;
    } h_t;
    en_t en_q[$];
    h_t  h_q[$];

    always @(negedge clk) begin
        if (bus.cell_en)
            en_q.push_back('{cyc, bus.cell_in, bus.cell_prevh, bus.cell_ci, bus.cell_cip});
        if (bus.h_valid && bus.h_ready)
            h_q.push_back('{bus.h_data, bus.h_of});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        int b = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!bus.s_ready && b < 500) begin
            tick(1);
            b++;
        end
        if (b >= 500) chk("push_timeout", 0, 1);
        tick(1);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_h(input int n, input string tag);
        int b = 0;
        while (h_q.size() < n && b < 400) begin
            tick(1);
            b++;
        end
        chk(tag, (h_q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_en(input int n, input string tag);
        int b = 0;
        while (en_q.size() < n && b < 400) begin
            tick(1);
            b++;
        end
        chk(tag, (en_q.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_prevh[3] = '{0, 10, 30};
        int exp_ci[3]    = '{0, 1, 2};
        int exp_cip[3]   = '{1, 0, 0};
        int exp_in[3]    = '{10, 20, 30};
        int b;

        // reset with a sample offered throughout; it must not be taken
        rst = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd99;
        bus.s_last  = 1'b1;
        bus.h_ready = 1'b0;
        tick(3);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_cell_en", bus.cell_en, 0);
        chk("rst_h_valid", bus.h_valid, 0);
        chk("rst_busy", bus.busy, 0);
        bus.s_valid = 1'b0;
        rst = 1'b0;
        tick(4);
        chk("rst_no_push_busy", bus.busy, 0);
        chk("rst_no_push_en", en_q.size(), 0);

        // basic three-step sequence
        bus.h_ready = 1'b1;
        push(8'd10, 1'b0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b1);
        wait_h(1, "seq1_done");
        tick(2);
        chk("seq1_npulse", en_q.size(), 3);
        for (int i = 0; i < 3 && i < en_q.size(); i++) begin
            chk($sformatf("seq1_in%0d", i), en_q[i].din, exp_in[i]);
            chk($sformatf("seq1_prevh%0d", i), en_q[i].prevh, exp_prevh[i]);
            chk($sformatf("seq1_ci%0d", i), en_q[i].ci, exp_ci[i]);
            chk($sformatf("seq1_cip%0d", i), en_q[i].cip, exp_cip[i]);
            if (i > 0) chk($sformatf("seq1_gap%0d", i), en_q[i].cyc - en_q[i-1].cyc, 4);
        end
        if (h_q.size() > 0) begin
            chk("seq1_h", h_q[0].d, 60);
            chk("seq1_of", h_q[0].o, 0);
        end
        chk("seq1_nh", h_q.size(), 1);

        // overflow then a fresh sequence
        en_q.delete();
        h_q.delete();
        push(8'd200, 1'b0);
        push(8'd100, 1'b1);
        wait_h(1, "ovf_done");
        if (h_q.size() > 0) begin
            chk("ovf_h", h_q[0].d, 44);
            chk("ovf_of", h_q[0].o, 1);
        end
        push(8'd5, 1'b1);
        wait_h(2, "ovf_next_done");
        if (h_q.size() > 1) begin
            chk("next_h", h_q[1].d, 5);
            chk("next_of", h_q[1].o, 0);
        end
        if (en_q.size() > 2) begin
            chk("next_cip", en_q[2].cip, 1);
            chk("next_prevh", en_q[2].prevh, 0);
            chk("next_ci", en_q[2].ci, 0);
        end

        // backpressure and FIFO full
        en_q.delete();
        h_q.delete();
        bus.h_ready = 1'b0;
        push(8'd1, 1'b1);
        b = 0;
        while (!bus.h_valid && b < 100) begin
            tick(1);
            b++;
        end
        chk("bp_done_reached", bus.h_valid, 1);
        for (int i = 0; i < 16; i++) push(8'(i + 2), (i == 15));
        chk("bp_full_ready", bus.s_ready, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd99;
        bus.s_last  = 1'b1;
        tick(3);
        chk("bp_still_full", bus.s_ready, 0);
        bus.s_valid = 1'b0;
        chk("bp_held_h", bus.h_data, 1);
        bus.h_ready = 1'b1;
        wait_h(2, "bp_drain_done");
        if (h_q.size() > 1) begin
            chk("bp_h0", h_q[0].d, 1);
            chk("bp_h1", h_q[1].d, 152);
            chk("bp_of1", h_q[1].o, 0);
        end
        tick(10);
        chk("bp_npulse", en_q.size(), 17);
        chk("bp_idle", bus.busy, 0);
        for (int i = 0; i < 16 && i + 1 < en_q.size(); i++)
            chk($sformatf("bp_in%0d", i), en_q[i+1].din, i + 2);

        // starvation mid-sequence
        en_q.delete();
        h_q.delete();
        push(8'd7, 1'b0);
        tick(20);
        chk("starve_idle", bus.busy, 0);
        chk("starve_nh", h_q.size(), 0);
        push(8'd8, 1'b1);
        wait_h(1, "starve_done");
        if (en_q.size() > 1) begin
            chk("starve_prevh", en_q[1].prevh, 7);
            chk("starve_cip", en_q[1].cip, 0);
            chk("starve_ci", en_q[1].ci, 1);
        end
        if (h_q.size() > 0) chk("starve_h", h_q[0].d, 15);

        // reset during the second step's wait
        en_q.delete();
        h_q.delete();
        push(8'd50, 1'b0);
        push(8'd60, 1'b0);
        push(8'd70, 1'b1);
        wait_en(2, "abort_step2");
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        chk("abort_nh", h_q.size(), 0);
        chk("abort_idle", bus.busy, 0);
        chk("abort_npulse", en_q.size(), 2);
        push(8'd3, 1'b1);
        wait_h(1, "abort_new_done");
        if (en_q.size() > 2) begin
            chk("abort_prevh", en_q[2].prevh, 0);
            chk("abort_cip", en_q[2].cip, 1);
            chk("abort_in", en_q[2].din, 3);
        end
        if (h_q.size() > 0) chk("abort_h", h_q[0].d, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
